key_code_capture: RTL and testbench

//  Sequential stage directly downstream of the 10-to-4 encoder (encoder10_4).

---
 rtl/key_capture_pkg.sv | 13 +
 rtl/key_code_capture_stability_counter.sv | 36 +++
 rtl/key_code_capture.sv | 177 +++++++++++++++++
 tb/tb_key_code_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_capture_pkg.sv
// Shared types and defaults for the key code capture stage.
package key_capture_pkg;

    localparam int unsigned CODE_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILTER,
        EMIT,
        HOLD
    } cap_state_t;

endpackage

// File: rtl/key_code_capture_stability_counter.sv
// Consecutive-cycle counter used to debounce presses and releases.
// 'last' flags that one more qualifying sample completes a STABLE_CYC run,
// so the caller can act on the same edge the run completes.
module stability_counter #(
    parameter int STABLE_CYC = 16,
    parameter int CNT_W      = $clog2(STABLE_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(STABLE_CYC);

    logic [CNT_W-1:0] cnt;

    // Clear beats load beats increment; the count saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc && cnt != MAX_V) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_V);

endmodule

// File: rtl/key_code_capture.sv
// Debounced key capture behind the 10-to-4 encoder: filters the code/flag
// pair, hands each accepted press out once over valid/ready, and shifts it
// into a small digit buffer for the display/entry logic.
module key_code_capture
    import key_capture_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEF,
    parameter int STABLE_CYC = 16,
    parameter int DIGITS     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CODE_W-1:0]            code_in,
    input  logic                         code_flag,
    input  logic                         clear,
    input  logic                         key_ready,
    output logic                         key_valid,
    output logic [CODE_W-1:0]            key_code,
    output logic [DIGITS*CODE_W-1:0]     digits_out,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic                         overflow
);

    localparam int CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int DCNT_W = $clog2(DIGITS + 1);
    localparam logic [DCNT_W-1:0] DIG_FULL = DCNT_W'(DIGITS);

    cap_state_t                     state;
    logic [CODE_W-1:0]              cand;
    logic [DIGITS-1:0][CODE_W-1:0]  digit_buf;

    logic match;
    logic capture;
    logic press_clr, press_load, press_inc, press_last;
    logic rel_clr, rel_inc, rel_last;

    assign match = code_flag && (code_in == cand);

    stability_counter #(
        .STABLE_CYC (STABLE_CYC),
        .CNT_W      (CNT_W)
    ) u_press_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (press_clr),
        .load (press_load),
        .inc  (press_inc),
        .last (press_last)
    );

    stability_counter #(
        .STABLE_CYC (STABLE_CYC),
        .CNT_W      (CNT_W)
    ) u_rel_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (rel_clr),
        .load (1'b0),
        .inc  (rel_inc),
        .last (rel_last)
    );

    // Counter steering and capture detect; capture is the edge entering EMIT.
    always_comb begin
        press_clr  = 1'b0;
        press_load = 1'b0;
        press_inc  = 1'b0;
        rel_clr    = 1'b1;
        rel_inc    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (code_flag) begin
                    if (STABLE_CYC == 1) capture    = 1'b1;
                    else                 press_load = 1'b1;
                end else begin
                    press_clr = 1'b1;
                end
            end
            FILTER: begin
                if (match) begin
                    if (press_last) begin
                        capture   = 1'b1;
                        press_clr = 1'b1;
                    end else begin
                        press_inc = 1'b1;
                    end
                end else if (code_flag) begin
                    press_load = 1'b1;
                end else begin
                    press_clr = 1'b1;
                end
            end
            EMIT: begin
                press_clr = 1'b1;
            end
            HOLD: begin
                press_clr = 1'b1;
                if (!code_flag && !rel_last) begin
                    rel_clr = 1'b0;
                    rel_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Capture FSM with registered handshake outputs; once a code is captured
    // it stays offered until taken, and the key must be released to re-arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else if (capture) begin
            state     <= EMIT;
            key_valid <= 1'b1;
            key_code  <= code_in;
        end else begin
            case (state)
                IDLE: begin
                    if (code_flag) begin
                        cand  <= code_in;
                        state <= FILTER;
                    end
                end
                FILTER: begin
                    if (!code_flag)  state <= IDLE;
                    else if (!match) cand  <= code_in;
                end
                EMIT: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!code_flag && rel_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit shift buffer: newest code enters slot 0; clear wins over old
    // contents but a code captured on the same edge is still kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_buf <= '0;
            digit_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (capture) begin
                if (clear) begin
                    digit_buf    <= '0;
                    digit_buf[0] <= code_in;
                    digit_cnt    <= DCNT_W'(1);
                end else begin
                    for (int i = DIGITS - 1; i > 0; i--) begin
                        digit_buf[i] <= digit_buf[i-1];
                    end
                    digit_buf[0] <= code_in;
                    if (digit_cnt == DIG_FULL) overflow  <= 1'b1;
                    else                       digit_cnt <= digit_cnt + 1'b1;
                end
            end else if (clear) begin
                digit_buf <= '0;
                digit_cnt <= '0;
            end
        end
    end

    assign digits_out = digit_buf;

endmodule

// File: tb/tb_key_code_capture.sv
// Randomized and scenario-driven bench for key_code_capture with a
// window-based reference model of press/release acceptance.
module tb_key_code_capture;

    localparam int CW = 4;
    localparam int SC = 4;
    localparam int DG = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] code_in;
    logic          code_flag;
    logic          clear;
    logic          key_ready;
    logic          key_valid;
    logic [CW-1:0] key_code;
    logic [DG*CW-1:0] digits_out;
    logic [$clog2(DG+1)-1:0] digit_cnt;
    logic          overflow;

    key_code_capture #(
        .CODE_W     (CW),
        .STABLE_CYC (SC),
        .DIGITS     (DG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_flag  (code_flag),
        .clear      (clear),
        .key_ready  (key_ready),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .digits_out (digits_out),
        .digit_cnt  (digit_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: sample history plus acceptance windows.
    bit          hf[$];
    logic [3:0]  hc[$];
    int          k;
    bit          m_valid, m_hold, m_ovf;
    int          m_arm_start, m_hold_start, m_cnt;
    logic [3:0]  m_code;
    logic [3:0]  dq[$];
    int          n_xfer, n_ovf;

    function automatic bit win_low(input int e);
        for (int j = e - SC + 1; j <= e; j++) if (hf[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit win_same(input int e);
        for (int j = e - SC + 1; j <= e; j++)
            if (!hf[j] || hc[j] != hc[e]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_digits();
        logic [15:0] v = '0;
        for (int i = 0; i < dq.size(); i++)
            v = v | (16'(dq[dq.size()-1-i]) << (4*i));
        return v;
    endfunction

    task automatic model_reset();
        hf.delete(); hc.delete(); dq.delete();
        k = 0; m_valid = 0; m_hold = 0; m_ovf = 0;
        m_arm_start = 0; m_hold_start = 0; m_cnt = 0; m_code = '0;
    endtask

    task automatic model_edge();
        bit cap = 1'b0;
        hf.push_back(code_flag);
        hc.push_back(code_in);
        if (m_valid) begin
            if (key_ready) begin
                m_valid = 0; m_hold = 1; m_hold_start = k + 1;
            end
        end else if (m_hold) begin
            if (k - SC + 1 >= m_hold_start && win_low(k)) begin
                m_hold = 0; m_arm_start = k + 1;
            end
        end else if (k - SC + 1 >= m_arm_start && win_same(k)) begin
            cap = 1; m_valid = 1; m_code = code_in;
        end
        m_ovf = 0;
        if (cap) begin
            if (clear) begin
                dq.delete(); dq.push_back(code_in); m_cnt = 1;
            end else begin
                m_ovf = (m_cnt == DG);
                dq.push_back(code_in);
                if (dq.size() > DG) void'(dq.pop_front());
                if (m_cnt < DG) m_cnt++;
            end
        end else if (clear) begin
            dq.delete(); m_cnt = 0;
        end
        k++;
    endtask

    task automatic tick();
        if (key_valid && key_ready) n_xfer++;
        @(posedge clk);
        model_edge();
        #1;
        if (overflow) n_ovf++;
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("key_code",  32'(key_code),  32'(m_code));
        chk("digits",    32'(digits_out), 32'(exp_digits()));
        chk("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    task automatic press(input logic [3:0] c, input int n);
        code_flag = 1'b1; code_in = c;
        repeat (n) tick();
    endtask

    task automatic release_key(input int n);
        code_flag = 1'b0; code_in = '0;
        repeat (n) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},  32'(key_valid),  32'd0);
        chk({tag, "_code"},   32'(key_code),   32'd0);
        chk({tag, "_digits"}, 32'(digits_out), 32'd0);
        chk({tag, "_cnt"},    32'(digit_cnt),  32'd0);
        chk({tag, "_ovf"},    32'(overflow),   32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk_zero("rst");
        rst = 1'b0;
        model_reset();
    endtask

    int x0, o0;

    initial begin
        rst = 1'b1; code_in = '0; code_flag = 1'b0; clear = 1'b0; key_ready = 1'b1;
        n_xfer = 0; n_ovf = 0;
        model_reset();
        #12;
        chk_zero("por");
        rst = 1'b0;

        // 1: single clean press
        x0 = n_xfer;
        press(4'd5, 4);
        release_key(8);
        chk("t1_xfer", 32'(n_xfer - x0), 32'd1);
        chk("t1_digits", 32'(digits_out), 32'h0005);
        chk("t1_cnt", 32'(digit_cnt), 32'd1);

        // 2: bounce from 3 to 7, only 7 is accepted
        x0 = n_xfer;
        press(4'd3, 2);
        press(4'd7, 4);
        release_key(8);
        chk("t2_xfer", 32'(n_xfer - x0), 32'd1);
        chk("t2_code", 32'(key_code), 32'd7);
        chk("t2_digits", 32'(digits_out), 32'h0057);

        // 3: backpressure, long hold, then next key after release
        x0 = n_xfer;
        key_ready = 1'b0;
        press(4'd6, 4);
        press(4'd6, 10);
        chk("t3_stall_valid", 32'(key_valid), 32'd1);
        chk("t3_stall_code", 32'(key_code), 32'd6);
        key_ready = 1'b1;
        press(4'd6, 50);
        chk("t3_held_xfer", 32'(n_xfer - x0), 32'd1);
        release_key(4);
        press(4'd2, 4);
        release_key(8);
        chk("t3_xfer", 32'(n_xfer - x0), 32'd2);
        chk("t3_code", 32'(key_code), 32'd2);

        // 4: five keys overflow a four-digit buffer once
        do_reset();
        o0 = n_ovf;
        for (int v = 1; v <= 5; v++) begin
            press(4'(v), 4);
            release_key(6);
        end
        chk("t4_digits", 32'(digits_out), 32'h2345);
        chk("t4_cnt", 32'(digit_cnt), 32'd4);
        chk("t4_ovf", 32'(n_ovf - o0), 32'd1);

        // 5: clear on the capture edge, then clear alone
        press(4'd9, 3);
        clear = 1'b1;
        press(4'd9, 1);
        clear = 1'b0;
        release_key(6);
        chk("t5_digits", 32'(digits_out), 32'h0009);
        chk("t5_cnt", 32'(digit_cnt), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clr_digits", 32'(digits_out), 32'd0);
        chk("t5_clr_cnt", 32'(digit_cnt), 32'd0);

        // 6: async reset while a code is offered
        key_ready = 1'b0;
        press(4'd4, 4);
        chk("t6_pre_valid", 32'(key_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(key_valid), 32'd0);
        chk("t6_digits", 32'(digits_out), 32'd0);
        chk("t6_cnt", 32'(digit_cnt), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        key_ready = 1'b1;
        release_key(2);
        press(4'd8, 4);
        release_key(6);
        chk("t6_after_digits", 32'(digits_out), 32'h0008);

        // Randomized traffic
        for (int s = 0; s < 150; s++) begin
            int len;
            code_flag = ($urandom_range(0, 3) != 0);
            code_in   = 4'($urandom_range(0, 9));
            len       = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                key_ready = ($urandom_range(0, 3) != 0);
                clear     = ($urandom_range(0, 19) == 0);
                tick();
            end
        end
        clear = 1'b0;
        key_ready = 1'b1;
        release_key(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
